// File: rtl/clockworks_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : clockworks_sequencer
// Description : Single-clock reset sequencer and debug clock-enable generator.
//               After a power-on hold period the staged active-low resets
//               are released one domain at a time. Once all domains are out
//               of reset, a registered clock-enable is produced in run,
//               power-of-two divided, debounced single-step or pause mode.
//               A synchronous soft reset restarts the whole sequence.
// Ports       : CLK       - board clock, rising edge
//               RESET     - asynchronous active-low board reset
//               soft_rst  - synchronous restart request
//               mode      - 00 run, 01 divided, 10 single-step, 11 pause
//               div_sel   - log2 of ce period in divided mode
//               step_btn  - raw push-button, active-high
//               ce        - registered clock-enable
//               resetn    - staged active-low resets, bit 0 released first
//               ready     - high once every domain has been released
// Revision    : 1.0 - initial release
// ============================================================================
module clockworks_sequencer #(
    parameter int unsigned N_DOMAINS     = 3,
    parameter int unsigned HOLD_BITS     = 16,
    parameter int unsigned STAGE_GAP     = 16,
    parameter int unsigned DIV_BITS      = 24,
    parameter int unsigned DEBOUNCE_BITS = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 soft_rst,
    input  logic [1:0]           mode,
    input  logic [4:0]           div_sel,
    input  logic                 step_btn,
    output logic                 ce,
    output logic [N_DOMAINS-1:0] resetn,
    output logic                 ready
);

    localparam int unsigned c_gap_w = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(STAGE_GAP - 1);

    localparam logic [1:0] c_mode_run  = 2'b00;
    localparam logic [1:0] c_mode_div  = 2'b01;
    localparam logic [1:0] c_mode_step = 2'b10;

    typedef enum logic [1:0] {
        S_HOLD  = 2'd0,
        S_STAGE = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Reset synchronizer: asserts asynchronously, releases after two edges.
    // Everything else advances only once the synchronized reset is high.
    // ------------------------------------------------------------------
    logic [1:0] r_rst_sync;
    logic       w_run;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_run = r_rst_sync[1];

    // ------------------------------------------------------------------
    // Step button: 2-flop synchronizer followed by a debouncer. Runs in all
    // sequencer states, so a press finishing before ready is simply lost.
    // ------------------------------------------------------------------
    logic [1:0]               r_btn_sync;
    logic                     r_btn_db;
    logic [DEBOUNCE_BITS-1:0] r_db_cnt;
    logic                     w_btn_synced;
    logic                     w_db_flip;
    logic                     w_step_rise;

    assign w_btn_synced = r_btn_sync[1];
    // The level flips on the 2^DEBOUNCE_BITS-th consecutive differing cycle.
    assign w_db_flip    = (w_btn_synced != r_btn_db) && (&r_db_cnt);
    assign w_step_rise  = w_db_flip && w_btn_synced;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_btn_sync <= 2'b00;
            r_btn_db   <= 1'b0;
            r_db_cnt   <= '0;
        end else if (w_run) begin
            r_btn_sync <= {r_btn_sync[0], step_btn};
            if (w_btn_synced != r_btn_db) begin
                if (&r_db_cnt) begin
                    r_btn_db <= w_btn_synced;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM: HOLD -> STAGE -> RUN.
    // resetn is a shift register filling with ones from bit 0, so released
    // domains stay released and the order is fixed by construction.
    // ------------------------------------------------------------------
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [HOLD_BITS-1:0]   r_hold_cnt;
    logic [HOLD_BITS-1:0]   w_hold_cnt_nxt;
    logic [c_gap_w-1:0]     r_gap_cnt;
    logic [c_gap_w-1:0]     w_gap_cnt_nxt;
    logic [N_DOMAINS-1:0]   r_resetn;
    logic [N_DOMAINS-1:0]   w_resetn_nxt;
    logic [N_DOMAINS-1:0]   w_resetn_shift;
    logic                   r_ready;
    logic                   w_ready_nxt;

    assign w_resetn_shift = (r_resetn << 1) | N_DOMAINS'(1);

    always_comb begin
        w_state_nxt    = r_state;
        w_hold_cnt_nxt = r_hold_cnt;
        w_gap_cnt_nxt  = r_gap_cnt;
        w_resetn_nxt   = r_resetn;
        w_ready_nxt    = r_ready;
        if (soft_rst) begin
            w_state_nxt    = S_HOLD;
            w_hold_cnt_nxt = '0;
            w_gap_cnt_nxt  = '0;
            w_resetn_nxt   = '0;
            w_ready_nxt    = 1'b0;
        end else begin
            case (r_state)
                S_HOLD: begin
                    if (&r_hold_cnt) begin
                        w_hold_cnt_nxt = '0;
                        w_gap_cnt_nxt  = '0;
                        w_resetn_nxt   = w_resetn_shift;
                        // A single domain goes straight to RUN.
                        if (&w_resetn_shift) begin
                            w_state_nxt = S_RUN;
                            w_ready_nxt = 1'b1;
                        end else begin
                            w_state_nxt = S_STAGE;
                        end
                    end else begin
                        w_hold_cnt_nxt = r_hold_cnt + 1'b1;
                    end
                end
                S_STAGE: begin
                    if (r_gap_cnt == c_gap_last) begin
                        w_gap_cnt_nxt = '0;
                        w_resetn_nxt  = w_resetn_shift;
                        if (&w_resetn_shift) begin
                            w_state_nxt = S_RUN;
                            w_ready_nxt = 1'b1;
                        end
                    end else begin
                        w_gap_cnt_nxt = r_gap_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                end
                default: begin
                    w_state_nxt = S_HOLD;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Clock-enable generation. The terminal count mask has its low
    // min(div_sel, DIV_BITS) bits set, i.e. 2^d - 1.
    // ------------------------------------------------------------------
    logic [DIV_BITS-1:0] w_div_term;
    logic [DIV_BITS-1:0] r_div_cnt;
    logic [DIV_BITS-1:0] w_div_cnt_nxt;
    logic [1:0]          r_mode_q;
    logic [4:0]          r_div_sel_q;
    logic                w_cfg_changed;
    logic                r_ce;
    logic                w_ce_nxt;

    for (genvar gi = 0; gi < DIV_BITS; gi++) begin : g_div_term
        assign w_div_term[gi] = ({27'd0, div_sel} > 32'(gi));
    end

    // Any mode or divider change restarts the divider with a ce gap.
    assign w_cfg_changed = (mode != r_mode_q) || (div_sel != r_div_sel_q);

    always_comb begin
        w_ce_nxt      = 1'b0;
        w_div_cnt_nxt = '0;
        if (!soft_rst && r_ready && !w_cfg_changed) begin
            case (mode)
                c_mode_run: begin
                    w_ce_nxt = 1'b1;
                end
                c_mode_div: begin
                    if (r_div_cnt == w_div_term) begin
                        w_ce_nxt = 1'b1;
                    end else begin
                        w_div_cnt_nxt = r_div_cnt + 1'b1;
                    end
                end
                c_mode_step: begin
                    w_ce_nxt = w_step_rise;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state     <= S_HOLD;
            r_hold_cnt  <= '0;
            r_gap_cnt   <= '0;
            r_resetn    <= '0;
            r_ready     <= 1'b0;
            r_div_cnt   <= '0;
            r_mode_q    <= 2'b00;
            r_div_sel_q <= 5'd0;
            r_ce        <= 1'b0;
        end else if (w_run) begin
            r_state     <= w_state_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
            r_gap_cnt   <= w_gap_cnt_nxt;
            r_resetn    <= w_resetn_nxt;
            r_ready     <= w_ready_nxt;
            r_div_cnt   <= w_div_cnt_nxt;
            r_mode_q    <= mode;
            r_div_sel_q <= div_sel;
            r_ce        <= w_ce_nxt;
        end
    end

    assign ce     = r_ce;
    assign resetn = r_resetn;
    assign ready  = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_clockworks_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_clockworks_sequencer
// Description : Directed self-checking bench for clockworks_sequencer with
//               small parameters (hold 16, gap 3, debounce 4, divider 8 bit).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clockworks_sequencer;

    localparam int unsigned N_DOMAINS     = 3;
    localparam int unsigned HOLD_BITS     = 4;
    localparam int unsigned STAGE_GAP     = 3;
    localparam int unsigned DIV_BITS      = 8;
    localparam int unsigned DEBOUNCE_BITS = 2;

    logic                 CLK;
    logic                 RESET;
    logic                 soft_rst;
    logic [1:0]           mode;
    logic [4:0]           div_sel;
    logic                 step_btn;
    logic                 ce;
    logic [N_DOMAINS-1:0] resetn;
    logic                 ready;

    int n_checks = 0;
    int n_errors = 0;
    int ce_seen  = 0;

    clockworks_sequencer #(
        .N_DOMAINS     (N_DOMAINS),
        .HOLD_BITS     (HOLD_BITS),
        .STAGE_GAP     (STAGE_GAP),
        .DIV_BITS      (DIV_BITS),
        .DEBOUNCE_BITS (DEBOUNCE_BITS)
    ) u_dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .soft_rst (soft_rst),
        .mode     (mode),
        .div_sel  (div_sel),
        .step_btn (step_btn),
        .ce       (ce),
        .resetn   (resetn),
        .ready    (ready)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; observe outputs 1 time unit later.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Advance n edges, counting cycles with ce high.
    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            if (ce === 1'b1) ce_seen++;
        end
    endtask

    // Edges until resetn[bitn] is high; -1 if it never rises.
    task automatic edges_until_release(input int bitn, output int n);
        n = -1;
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (resetn[bitn] === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        int          n;
        int          bad;
        int          first_k;
        int          second_k;
        logic [31:0] pat;

        RESET    = 1'b0;
        soft_rst = 1'b0;
        mode     = 2'b00;
        div_sel  = 5'd0;
        step_btn = 1'b0;

        // ---------------- 1: power-on sequence ----------------
        repeat (5) tick();
        check("rst_resetn", {29'd0, resetn}, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_ce", {31'd0, ce}, 32'd0);

        RESET = 1'b1;
        edges_until_release(0, n);
        check("por_r0_edges", n, 32'd18);
        check("por_r0_vec", {29'd0, resetn}, 32'd1);
        check("por_ce_pre", {31'd0, ce}, 32'd0);
        check("por_ready_pre", {31'd0, ready}, 32'd0);
        edges_until_release(1, n);
        check("por_r1_gap", n, 32'd3);
        check("por_r1_ready", {31'd0, ready}, 32'd0);
        edges_until_release(2, n);
        check("por_r2_gap", n, 32'd3);
        check("por_ready", {31'd0, ready}, 32'd1);
        check("por_ce_at_ready", {31'd0, ce}, 32'd0);
        tick();
        check("por_ce_run", {31'd0, ce}, 32'd1);
        check("por_resetn_all", {29'd0, resetn}, 32'd7);

        // ---------------- 2: divided mode ----------------
        mode    = 2'b01;
        div_sel = 5'd2;
        pat     = '0;
        for (int i = 0; i < 16; i++) begin
            tick();
            pat[i] = ce;
        end
        check("div4_pattern", pat, 32'h0000_1110);

        div_sel = 5'd0;
        pat     = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            pat[i] = ce;
        end
        check("div1_pattern", pat, 32'h0000_00FE);

        div_sel  = 5'd31;
        first_k  = 0;
        second_k = 0;
        for (int k = 1; k <= 520; k++) begin
            tick();
            if (ce === 1'b1) begin
                if (first_k == 0) first_k = k;
                else if (second_k == 0) second_k = k;
            end
        end
        check("div_clip_first", first_k, 32'd257);
        check("div_clip_second", second_k, 32'd513);

        // ---------------- 6b: pause mode ----------------
        mode    = 2'b11;
        ce_seen = 0;
        run(100);
        check("pause_ce_count", ce_seen, 32'd0);
        mode = 2'b00;
        tick();
        check("run_gap_after_change", {31'd0, ce}, 32'd0);
        tick();
        check("run_ce_back", {31'd0, ce}, 32'd1);

        // ---------------- 3: single-step ----------------
        mode = 2'b10;
        run(5);
        ce_seen = 0;
        for (int g = 1; g <= 3; g++) begin
            step_btn = 1'b1;
            run(g);
            step_btn = 1'b0;
            run(10);
        end
        check("step_glitch_none", ce_seen, 32'd0);

        ce_seen  = 0;
        step_btn = 1'b1;
        run(10);
        check("step_press_one", ce_seen, 32'd1);
        run(100);
        check("step_hold_no_more", ce_seen, 32'd1);
        step_btn = 1'b0;
        run(20);
        check("step_release_none", ce_seen, 32'd1);
        step_btn = 1'b1;
        run(10);
        check("step_repress_one", ce_seen, 32'd2);
        step_btn = 1'b0;
        run(10);

        // ---------------- 4: soft reset ----------------
        mode = 2'b00;
        run(3);
        soft_rst = 1'b1;
        bad      = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (resetn !== '0 || ready !== 1'b0 || ce !== 1'b0) bad++;
        end
        check("soft_hold_low", bad, 32'd0);
        soft_rst = 1'b0;
        edges_until_release(0, n);
        check("soft_r0_edges", n, 32'd16);

        soft_rst = 1'b1;
        tick();
        check("soft_stage_resetn", {29'd0, resetn}, 32'd0);
        check("soft_stage_ready", {31'd0, ready}, 32'd0);
        soft_rst = 1'b0;
        edges_until_release(0, n);
        check("soft2_r0_edges", n, 32'd16);
        edges_until_release(1, n);
        check("soft2_r1_gap", n, 32'd3);
        edges_until_release(2, n);
        check("soft2_r2_gap", n, 32'd3);
        check("soft2_ready", {31'd0, ready}, 32'd1);
        tick();
        check("soft2_ce_run", {31'd0, ce}, 32'd1);

        // ---------------- 5: asynchronous board reset ----------------
        tick();
        #3;
        RESET = 1'b0;
        #1;
        check("async_resetn", {29'd0, resetn}, 32'd0);
        check("async_ready", {31'd0, ready}, 32'd0);
        check("async_ce", {31'd0, ce}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
